// File: rtl/bitwise_logic_pipe_if.sv
// Operand/result handshake bundle for the bitwise logic-op unit.
// The master drives operands and out_ready. The slave (the pipe) drives results and in_ready.
interface bitwise_logic_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic             acc_mode;
    logic             acc_clr;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             out_zero;

    modport master (
        output in_valid, op, acc_mode, acc_clr, a, b, out_ready,
        input  in_ready, out_valid, out, out_zero
    );

    modport slave (
        input  in_valid, op, acc_mode, acc_clr, a, b, out_ready,
        output in_ready, out_valid, out, out_zero
    );
endinterface

// File: rtl/bitwise_logic_pipe.sv
// Two-stage valid/ready bitwise logic unit with an optional accumulator as operand B.
// It also keeps a saturating count of results delivered downstream.
module bitwise_logic_pipe #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    bitwise_logic_pipe_if.slave  bus,
    output logic [WIDTH-1:0]     o_acc,
    output logic [CNT_W-1:0]     o_res_count
);
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [2:0]       r_s1_op;
    logic             r_s1_acc_mode;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out;
    logic             r_out_zero;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_res_count;

    logic             w_s2_free;
    logic             w_s1_move;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_deliver;
    logic [WIDTH-1:0] w_bsel;
    logic [WIDTH-1:0] w_result;

    assign w_s2_free  = !r_out_valid || bus.out_ready;
    assign w_s1_move  = r_s1_valid && w_s2_free;
    assign w_in_ready = !r_s1_valid || w_s2_free;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_deliver  = r_out_valid && bus.out_ready;

    // The accumulator is read at the S1->S2 transfer, so back-to-back accumulate beats chain.
    assign w_bsel = r_s1_acc_mode ? r_acc : r_s1_b;

    always_comb begin
        w_result = '0;
        unique case (r_s1_op)
            3'b000:  w_result = r_s1_a & w_bsel;
            3'b001:  w_result = r_s1_a | w_bsel;
            3'b010:  w_result = r_s1_a ^ w_bsel;
            3'b011:  w_result = ~(r_s1_a ^ w_bsel);
            3'b100:  w_result = ~(r_s1_a & w_bsel);
            3'b101:  w_result = ~(r_s1_a | w_bsel);
            3'b110:  w_result = ~r_s1_a;
            default: w_result = r_s1_a;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid    <= 1'b0;
            r_s1_a        <= '0;
            r_s1_b        <= '0;
            r_s1_op       <= '0;
            r_s1_acc_mode <= 1'b0;
        end else if (w_accept) begin
            r_s1_valid    <= 1'b1;
            r_s1_a        <= bus.a;
            r_s1_b        <= bus.b;
            r_s1_op       <= bus.op;
            r_s1_acc_mode <= bus.acc_mode;
        end else if (w_s1_move) begin
            r_s1_valid    <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_out_zero  <= 1'b0;
        end else if (w_s1_move) begin
            r_out_valid <= 1'b1;
            r_out       <= w_result;
            r_out_zero  <= (w_result == '0);
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // A clear takes priority over a coincident accumulate write-back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (bus.acc_clr) begin
            r_acc <= '0;
        end else if (w_s1_move && r_s1_acc_mode) begin
            r_acc <= w_result;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_count <= '0;
        end else if (w_deliver && (r_res_count != {CNT_W{1'b1}})) begin
            r_res_count <= r_res_count + 1'b1;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out       = r_out;
    assign bus.out_zero  = r_out_zero;
    assign o_acc         = r_acc;
    assign o_res_count   = r_res_count;
endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Self-checking bench for bitwise_logic_pipe: directed table, corner sequences,
// and a randomized phase scored against a queue-based reference.
module tb_bitwise_logic_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bitwise_logic_pipe_if #(.WIDTH(16)) bus16 ();
    bitwise_logic_pipe_if #(.WIDTH(8))  bus8 ();
    logic [15:0] acc16;
    logic [15:0] cnt16;
    logic [7:0]  acc8;
    logic [1:0]  cnt8;

    bitwise_logic_pipe #(.WIDTH(16), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .bus(bus16), .o_acc(acc16), .o_res_count(cnt16));
    bitwise_logic_pipe #(.WIDTH(8), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .bus(bus8), .o_acc(acc8), .o_res_count(cnt8));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_op(input logic [2:0] op, input logic [15:0] a,
                                           input logic [15:0] b);
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a ^ b;
            3'd3: return ~(a ^ b);
            3'd4: return ~(a & b);
            3'd5: return ~(a | b);
            3'd6: return ~a;
            default: return a;
        endcase
    endfunction

    // Reference for random phase: results computed in acceptance order, compared on delivery.
    logic        mon_en = 1'b0;
    logic [15:0] exp_q[$];
    logic [15:0] m_acc = '0;
    int          m_cnt = 0;

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (bus16.out_valid && bus16.out_ready) begin
                m_cnt++;
                if (exp_q.size() == 0) check("rand_unexpected_out", 1, 0);
                else check("rand_out", bus16.out, exp_q.pop_front());
            end
            if (bus16.in_valid && bus16.in_ready) begin
                logic [15:0] r;
                r = ref_op(bus16.op, bus16.a, bus16.acc_mode ? m_acc : bus16.b);
                if (bus16.acc_mode) m_acc = r;
                exp_q.push_back(r);
            end
        end
    end

    task automatic drive16(input logic v, input logic [2:0] op, input logic [15:0] a,
                           input logic [15:0] b, input logic am);
        bus16.in_valid = v;
        bus16.op       = op;
        bus16.a        = a;
        bus16.b        = b;
        bus16.acc_mode = am;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{3'b011, 16'h3efd, 16'h1234, 16'hd336};
        vecs[1] = '{3'b000, 16'hf0f0, 16'hff00, 16'hf000};
        vecs[2] = '{3'b001, 16'hf0f0, 16'hff00, 16'hfff0};
        vecs[3] = '{3'b010, 16'hf0f0, 16'hff00, 16'h0ff0};
        vecs[4] = '{3'b011, 16'hf0f0, 16'hff00, 16'hf00f};
        vecs[5] = '{3'b100, 16'hf0f0, 16'hff00, 16'h0fff};
        vecs[6] = '{3'b101, 16'hf0f0, 16'hff00, 16'h000f};
        vecs[7] = '{3'b110, 16'hf0f0, 16'hff00, 16'h0f0f};
        vecs[8] = '{3'b111, 16'hf0f0, 16'hff00, 16'hf0f0};

        drive16(1'b0, 3'd0, 16'h0, 16'h0, 1'b0);
        bus16.acc_clr = 1'b0; bus16.out_ready = 1'b1;
        bus8.in_valid = 1'b0; bus8.op = 3'd0; bus8.a = 8'h0; bus8.b = 8'h0;
        bus8.acc_mode = 1'b0; bus8.acc_clr = 1'b0; bus8.out_ready = 1'b1;

        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_out_valid", bus16.out_valid, 0);
        check("rst_out", bus16.out, 0);
        check("rst_out_zero", bus16.out_zero, 0);
        check("rst_acc", acc16, 0);
        check("rst_count", cnt16, 0);
        check("rst_in_ready", bus16.in_ready, 1);
        check("rst_count8", cnt8, 0);

        // Table: each beat checked exactly two edges after it is presented.
        for (int i = 0; i < 9; i++) begin
            drive16(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
            tick();
            bus16.in_valid = 1'b0;
            tick();
            check($sformatf("vec%0d_valid", i), bus16.out_valid, 1);
            check($sformatf("vec%0d_out", i), bus16.out, vecs[i].exp);
            check($sformatf("vec%0d_zero", i), bus16.out_zero, vecs[i].exp == 16'h0);
        end
        tick();

        // Accumulate chain: clear, then two back-to-back XOR beats.
        bus16.acc_clr = 1'b1;
        tick();
        bus16.acc_clr = 1'b0;
        check("acc_cleared", acc16, 0);
        drive16(1'b1, 3'b010, 16'h00ff, 16'hdead, 1'b1);
        tick();
        drive16(1'b1, 3'b010, 16'h0f0f, 16'hbeef, 1'b1);
        tick();
        bus16.in_valid = 1'b0;
        check("acc1_out", bus16.out, 16'h00ff);
        check("acc1_acc", acc16, 16'h00ff);
        tick();
        check("acc2_out", bus16.out, 16'h0ff0);
        check("acc2_acc", acc16, 16'h0ff0);

        // Clear coinciding with an accumulate write-back: clear wins, out still carries result.
        drive16(1'b1, 3'b001, 16'h1000, 16'h0000, 1'b1);
        tick();
        bus16.in_valid = 1'b0;
        bus16.acc_clr  = 1'b1;
        tick();
        bus16.acc_clr  = 1'b0;
        check("clr_win_out", bus16.out, 16'h1ff0);
        check("clr_win_acc", acc16, 16'h0000);
        tick();

        // Backpressure: two beats fill the pipe, third is stalled; out held stable.
        bus16.out_ready = 1'b0;
        drive16(1'b1, 3'b010, 16'h1111, 16'h0001, 1'b0);
        tick();
        drive16(1'b1, 3'b010, 16'h2222, 16'h0002, 1'b0);
        tick();
        drive16(1'b1, 3'b010, 16'h3333, 16'h0003, 1'b0);
        check("bp_in_ready_low", bus16.in_ready, 0);
        check("bp_out0", bus16.out, 16'h1110);
        repeat (3) tick();
        check("bp_hold_valid", bus16.out_valid, 1);
        check("bp_hold_out", bus16.out, 16'h1110);
        check("bp_hold_in_ready", bus16.in_ready, 0);
        bus16.out_ready = 1'b1;
        tick();
        bus16.in_valid = 1'b0;
        check("bp_out1", bus16.out, 16'h2220);
        tick();
        check("bp_out2", bus16.out, 16'h3330);
        check("bp_out2_valid", bus16.out_valid, 1);
        tick();
        check("bp_drained", bus16.out_valid, 0);

        // Reset with two beats in flight.
        bus16.out_ready = 1'b0;
        drive16(1'b1, 3'b111, 16'h00ff, 16'h0000, 1'b1);
        tick();
        drive16(1'b1, 3'b000, 16'hffff, 16'h1234, 1'b0);
        tick();
        bus16.in_valid = 1'b0;
        check("pre_rst_acc", acc16, 16'h00ff);
        check("pre_rst_valid", bus16.out_valid, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", bus16.out_valid, 0);
        check("mid_rst_acc", acc16, 0);
        check("mid_rst_count", cnt16, 0);
        check("mid_rst_out", bus16.out, 0);
        tick();
        rst = 1'b0;
        bus16.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("post_rst_stale%0d", i), bus16.out_valid, 0);
        end

        // 8-bit instance: zero flag and 2-bit saturating counter.
        bus8.in_valid = 1'b1; bus8.op = 3'b010; bus8.a = 8'haa; bus8.b = 8'haa;
        tick();
        bus8.in_valid = 1'b0;
        tick();
        check("w8_out", bus8.out, 8'h00);
        check("w8_zero", bus8.out_zero, 1);
        tick();
        check("w8_count1", cnt8, 1);
        bus8.in_valid = 1'b1; bus8.op = 3'b001; bus8.b = 8'h01;
        repeat (4) tick();
        bus8.in_valid = 1'b0;
        repeat (4) tick();
        check("w8_count_sat", cnt8, 2'd3);
        check("w8_last_zero", bus8.out_zero, 0);

        // Randomized phase (accumulator clear held low so the model can order by acceptance).
        m_acc = acc16;
        m_cnt = 0;
        mon_en = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            drive16(($urandom % 4) != 0, 3'($urandom % 8), 16'($urandom), 16'($urandom),
                    ($urandom % 3) == 0);
            bus16.out_ready = ($urandom % 3) != 0;
            tick();
        end
        bus16.in_valid  = 1'b0;
        bus16.out_ready = 1'b1;
        for (int i = 0; i < 20 && (exp_q.size() != 0 || bus16.out_valid); i++) tick();
        @(negedge clk);
        mon_en = 1'b0;
        check("rand_drained", exp_q.size(), 0);
        check("rand_acc", acc16, m_acc);
        check("rand_count", cnt16, 16'(m_cnt));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
